seq_word_serializer: RTL and testbench
======================================

Name: seq_word_serializer

Overview:
- Parallel-to-serial stage directly upstream of the single-bit pattern-detector FSMs.
- Accepts nbits-wide words over a val/rdy handshake and emits them one bit per cycle on a 1-bit stream. Back-to-back words produce gap-free output.
- When no word is in flight, the stream carries 0, which the downstream detector treats as ordinary idle input.

Parameters:
- nbits, 8, word width in bits; legal range 2..32.
- lsb_first, 0, 0 = send MSB first, 1 = send LSB first.

Ports:
- clk      input   1      clock; all state updates on the rising edge
- reset    input   1      asynchronous, active-high reset
- in_      input   nbits  parallel word to serialize
- in_val   input   1      in_ holds a valid word
- in_rdy   output  1      block can accept a word this cycle
- out      output  1      serial bit stream; feeds a detector's in_
- out_val  output  1      out carries a bit of a word (1) or idle fill (0)

Behaviour:
- Handshake
  - A transfer occurs on a rising edge where in_val && in_rdy.
  - in_val may rise or fall at any time. in_ is sampled only on a transfer edge.
- States: IDLE, SHIFT (2-state FSM), plus:
  - shift register sreg[nbits]
  - bit counter cnt, width clog2(nbits), counting 0..nbits-1
- Reset (asynchronous, immediate)
  - state=IDLE, cnt=0, sreg=0.
  - Outputs: out=0, out_val=0, in_rdy=0 while reset is high. in_rdy=1 from the first cycle after reset deasserts.
- Output rules (combinational from registers; Moore for out/out_val)
  - out_val = (state==SHIFT).
  - out = sreg[nbits-1] (lsb_first=0) or sreg[0] (lsb_first=1) when in SHIFT; 0 in IDLE.
  - in_rdy = !reset && (state==IDLE || (state==SHIFT && cnt==nbits-1)).
- Transitions
  - IDLE, transfer: load sreg<=in_, cnt<=0, go to SHIFT.
  - IDLE, no transfer: stay in IDLE.
  - SHIFT, cnt<nbits-1: shift sreg one position toward the output end, filling with 0; cnt<=cnt+1.
  - SHIFT, cnt==nbits-1, transfer: reload sreg<=in_, cnt<=0, stay in SHIFT. No idle bit is inserted.
  - SHIFT, cnt==nbits-1, no transfer: go to IDLE, cnt<=0.
- Latency
  - A word accepted at edge k has its first bit on out during the cycle after edge k.
  - Bit i appears in cycle k+1+i. Sustained throughput is 1 word per nbits cycles.
- Boundary conditions
  - in_val held high while in_rdy=0: no transfer; in_ changes are ignored.
  - Reset mid-word: the remaining bits are discarded. out/out_val drop to 0 immediately (asynchronous).
  - cnt never exceeds nbits-1. No wrap-around other than the reload to 0.
- No X on any output after reset. in_ is never propagated to out combinationally.

Decomposition:
- Shared package seq_pkg:
  - typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t
  - localparam helper for the counter width, clog2(nbits)
- One sub-module is natural: seq_bit_counter.
  - Parameterized mod-nbits counter with clear/enable and a last flag (cnt==nbits-1).
  - Async reset; reusable by a future deserializer stage.
- The FSM, shift register and handshake logic stay in the top module.

Test Plan:
- Reset with nbits=8, lsb_first=0:
  - out=0, out_val=0, in_rdy=0 during reset.
  - First idle cycle after reset: in_rdy=1, out=0.
- Single word, in_=8'b1010_0000 accepted at cycle 0:
  - out = 1,0,1,0,0,0,0,0 on cycles 1..8 with out_val=1.
  - in_rdy=1 only on cycle 8.
  - Cycle 9: out_val=0, out=0.
- Back-to-back: in_val held high with 8'hA0 then 8'h0D:
  - 16 contiguous valid bits 10100000_00001101, with no gap.
  - in_rdy pulses on cycle 8. A downstream 101-detector fires on the expected cycles.
- Stall: in_val=1 and in_ changing every cycle while in SHIFT:
  - Only the value present at the in_rdy=1 edge is serialized.
- Reset mid-word: assert reset after the 3rd bit of 8'hFF:
  - out and out_val go to 0 immediately.
  - After release, the next word 8'h81 is emitted cleanly as 1,0,0,0,0,0,0,1.
- lsb_first=1, nbits=4, in_=4'b0011:
  - out = 1,1,0,0. in_rdy is high on the 4th bit cycle.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and helpers for the sequence-detector datapath.
// Revision    : 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Counter width for a mod-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_bit_counter
// Description : Mod-NBITS counter with clear, enable and a terminal-count flag.
// Revision    : 1.0
// ============================================================================
module seq_bit_counter #(
    parameter int NBITS = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(NBITS - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over enable; the terminal count wraps straight back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/seq_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_word_serializer
// Description : Parallel-to-serial converter with val/rdy input, gap-free
//               back-to-back output and zero idle fill.
// Revision    : 1.0
// ============================================================================
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] in_,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out,
    output logic             out_val
);

    localparam int               c_cnt_w = cnt_width(NBITS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NBITS - 1);

    ser_state_t         r_state;
    logic [NBITS-1:0]   r_sreg;
    logic [NBITS-1:0]   w_shifted;
    logic               w_out_bit;
    logic [c_cnt_w-1:0] w_cnt;
    logic               w_last;
    logic               w_xfer;
    logic               w_shifting;

    assign w_shifting = (r_state == SER_SHIFT);
    assign w_xfer     = in_val && in_rdy;

    seq_bit_counter #(
        .NBITS (NBITS),
        .CNT_W (c_cnt_w)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_xfer),
        .i_en   (w_shifting),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = r_sreg >> 1;
            assign w_out_bit = r_sreg[0];
        end else begin : g_msb_first
            assign w_shifted = r_sreg << 1;
            assign w_out_bit = r_sreg[NBITS-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SER_IDLE;
            r_sreg  <= '0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (w_xfer) begin
                        r_sreg  <= in_;
                        r_state <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    if (!w_last) begin
                        r_sreg <= w_shifted;
                    end else if (w_xfer) begin
                        // Reload on the last bit keeps the stream gap-free.
                        r_sreg <= in_;
                    end else begin
                        r_sreg  <= '0;
                        r_state <= SER_IDLE;
                    end
                end
                default: begin
                    r_state <= SER_IDLE;
                    r_sreg  <= '0;
                end
            endcase
        end
    end

    assign out_val = w_shifting;
    assign out     = w_shifting && w_out_bit;
    assign in_rdy  = !reset && ((r_state == SER_IDLE) || (w_shifting && (w_cnt == c_last)));

endmodule
`default_nettype wire

// File: tb/tb_seq_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_word_serializer
// Description : Self-checking bench: vector tables, corner sequences and
//               random traffic against a bit-queue reference model.
// Revision    : 1.0
// ============================================================================
module tb_seq_word_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] in8;
    logic       in_val8, in_rdy8, out8, out_val8;
    logic [3:0] in4;
    logic       in_val4, in_rdy4, out4, out_val4;

    int total = 0;
    int bad   = 0;

    // Reference model: the bits still owed on each stream, front = on the wire now.
    bit q8[$];
    bit q4[$];

    bit cap = 0;
    bit cap_bits[$];
    bit cap_vals[$];

    seq_word_serializer #(.NBITS(8), .LSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset(reset), .in_(in8), .in_val(in_val8),
        .in_rdy(in_rdy8), .out(out8), .out_val(out_val8)
    );

    seq_word_serializer #(.NBITS(4), .LSB_FIRST(1'b1)) dut4 (
        .clk(clk), .reset(reset), .in_(in4), .in_val(in_val4),
        .in_rdy(in_rdy4), .out(out4), .out_val(out_val4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_out;
        logic       e_val;
        logic       e_rdy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input logic v8, input logic [7:0] d8,
                        input logic v4, input logic [3:0] d4, input bit chk);
        bit acc8, acc4;
        in_val8 = v8; in8 = d8; in_val4 = v4; in4 = d4;
        #1;
        if (chk) begin
            check("out8",     out8,     (q8.size() != 0) ? 32'(q8[0]) : 32'd0);
            check("out_val8", out_val8, 32'(q8.size() != 0));
            check("in_rdy8",  in_rdy8,  32'(q8.size() <= 1));
            check("out4",     out4,     (q4.size() != 0) ? 32'(q4[0]) : 32'd0);
            check("out_val4", out_val4, 32'(q4.size() != 0));
            check("in_rdy4",  in_rdy4,  32'(q4.size() <= 1));
        end
        if (cap) begin
            cap_bits.push_back(out8);
            cap_vals.push_back(out_val8);
        end
        @(posedge clk);
        acc8 = v8 && (q8.size() <= 1);
        acc4 = v4 && (q4.size() <= 1);
        if (q8.size() != 0) void'(q8.pop_front());
        if (q4.size() != 0) void'(q4.pop_front());
        if (acc8) for (int i = 7; i >= 0; i--) q8.push_back(d8[i]);
        if (acc4) for (int i = 0; i < 4; i++)  q4.push_back(d4[i]);
        @(negedge clk);
    endtask

    initial begin
        vec_t       tab8[10];
        vec_t       tab4[6];
        logic [7:0] pat8;
        logic [3:0] pat4;
        logic [15:0] bits16, vals16;
        logic [7:0]  bits8;
        int          hits;

        reset = 1'b1; in8 = '0; in_val8 = 1'b0; in4 = '0; in_val4 = 1'b0;
        #1;
        check("rst_out8",    out8,     32'd0);
        check("rst_val8",    out_val8, 32'd0);
        check("rst_rdy8",    in_rdy8,  32'd0);
        check("rst_rdy4",    in_rdy4,  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single MSB-first word 8'hA0.
        pat8 = 8'hA0;
        tab8[0] = '{v: 1'b1, d: pat8, e_out: 1'b0, e_val: 1'b0, e_rdy: 1'b1};
        for (int i = 1; i <= 8; i++)
            tab8[i] = '{v: 1'b0, d: 8'h00, e_out: pat8[8-i], e_val: 1'b1, e_rdy: (i == 8)};
        tab8[9] = '{v: 1'b0, d: 8'h00, e_out: 1'b0, e_val: 1'b0, e_rdy: 1'b1};
        for (int i = 0; i < 10; i++) begin
            in_val8 = tab8[i].v; in8 = tab8[i].d;
            #1;
            check($sformatf("tab8_out[%0d]", i), out8,     32'(tab8[i].e_out));
            check($sformatf("tab8_val[%0d]", i), out_val8, 32'(tab8[i].e_val));
            check($sformatf("tab8_rdy[%0d]", i), in_rdy8,  32'(tab8[i].e_rdy));
            tick(tab8[i].v, tab8[i].d, 1'b0, 4'h0, 1'b0);
        end

        // Single LSB-first 4-bit word 4'b0011.
        pat4 = 4'b0011;
        tab4[0] = '{v: 1'b1, d: {4'h0, pat4}, e_out: 1'b0, e_val: 1'b0, e_rdy: 1'b1};
        for (int i = 1; i <= 4; i++)
            tab4[i] = '{v: 1'b0, d: 8'h00, e_out: pat4[i-1], e_val: 1'b1, e_rdy: (i == 4)};
        tab4[5] = '{v: 1'b0, d: 8'h00, e_out: 1'b0, e_val: 1'b0, e_rdy: 1'b1};
        for (int i = 0; i < 6; i++) begin
            in_val4 = tab4[i].v; in4 = tab4[i].d[3:0];
            #1;
            check($sformatf("tab4_out[%0d]", i), out4,     32'(tab4[i].e_out));
            check($sformatf("tab4_val[%0d]", i), out_val4, 32'(tab4[i].e_val));
            check($sformatf("tab4_rdy[%0d]", i), in_rdy4,  32'(tab4[i].e_rdy));
            tick(1'b0, 8'h00, tab4[i].v, tab4[i].d[3:0], 1'b0);
        end

        // Back-to-back A0 then 0D with in_val held high throughout.
        tick(1'b1, 8'hA0, 1'b0, 4'h0, 1'b1);
        cap = 1; cap_bits.delete(); cap_vals.delete();
        for (int i = 0; i < 7; i++) tick(1'b1, 8'hA0, 1'b0, 4'h0, 1'b1);
        tick(1'b1, 8'h0D, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        cap = 0;
        tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bits16[15-i] = cap_bits[i];
            vals16[15-i] = cap_vals[i];
        end
        check("b2b_bits", bits16, 32'h0000_A00D);
        check("b2b_gapfree", vals16, 32'h0000_FFFF);
        hits = 0;
        for (int i = 2; i < 16; i++)
            if (cap_bits[i-2] && !cap_bits[i-1] && cap_bits[i]) hits++;
        check("b2b_101_hits", hits, 32'd2);

        // Stall: in_val high with new data every cycle while shifting.
        for (int i = 0; i < 20; i++)
            tick(1'b1, 8'($urandom), 1'b1, 4'($urandom), 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

        // Reset after the third bit of 8'hFF.
        tick(1'b1, 8'hFF, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out8", out8,     32'd0);
        check("midrst_val8", out_val8, 32'd0);
        check("midrst_rdy8", in_rdy8,  32'd0);
        q8.delete(); q4.delete();
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 8'h81, 1'b0, 4'h0, 1'b1);
        cap = 1; cap_bits.delete(); cap_vals.delete();
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        cap = 0;
        tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) bits8[7-i] = cap_bits[i];
        check("post_rst_word", bits8, 32'h81);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++)
            tick(($urandom % 10) < 7, 8'($urandom), ($urandom % 10) < 6, 4'($urandom), 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
